// File: rtl/lsu_core.sv
// Load/store unit owning the 16-bit memory bus: arbitrates RMW write-backs over
// scheduler loads/stores, returns load data with a register tag, and aborts stalled transfers.
module lsu_core #(
  parameter int TAG_W       = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             sched_req,
  input  logic             sched_we,
  input  logic [15:0]      sched_addr,
  input  logic [15:0]      sched_data,
  input  logic [TAG_W-1:0] sched_tag,
  output logic             sched_ack,
  input  logic             rmw_data_rdy,
  input  logic [15:0]      rmw_addr,
  input  logic [15:0]      rmw_data,
  input  logic             rmw_deny_op,
  output logic             rmw_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_data_out,
  input  logic             mem_rdy,
  input  logic [15:0]      mem_data_in,
  output logic             rf_wr,
  output logic [TAG_W-1:0] rf_wr_tag,
  output logic [15:0]      rf_wr_data,
  output logic             bus_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  localparam logic [7:0] WD_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       wd_q, wd_d;
  logic             guard_q, guard_d;
  logic             rf_wr_q, rf_wr_d;
  logic [TAG_W-1:0] rf_tag_q, rf_tag_d;
  logic [15:0]      rf_data_q, rf_data_d;
  logic             bus_err_q, bus_err_d;
  logic             idle, xfer_done, xfer_timeout;

  always_comb begin
    idle         = (state_q == IDLE);
    rmw_ack      = idle & rmw_data_rdy & ~guard_q;
    sched_ack    = idle & sched_req & ~rmw_ack & ~rmw_deny_op;
    mem_req      = ~idle;
    mem_we       = (state_q == WRITE);
    mem_addr     = addr_q;
    mem_data_out = wdata_q;
    busy         = ~idle;
    rf_wr        = rf_wr_q;
    rf_wr_tag    = rf_tag_q;
    rf_wr_data   = rf_data_q;
    bus_err      = bus_err_q;
    xfer_done    = mem_req & mem_rdy;
    xfer_timeout = mem_req & ~mem_rdy & (wd_q == WD_LAST);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tag_d     = tag_q;
    wd_d      = wd_q;
    // Guard survives the write and drops after one IDLE cycle, so an RMW stage
    // still presenting rmw_data_rdy right after completion cannot be re-accepted.
    guard_d   = idle ? 1'b0 : guard_q;
    rf_wr_d   = 1'b0;
    rf_tag_d  = rf_tag_q;
    rf_data_d = rf_data_q;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rmw_ack) begin
          addr_d  = rmw_addr;
          wdata_d = rmw_data;
          wd_d    = 8'd0;
          guard_d = 1'b1;
          state_d = WRITE;
        end else if (sched_ack) begin
          addr_d  = sched_addr;
          wdata_d = sched_we ? sched_data : 16'd0;
          tag_d   = sched_tag;
          wd_d    = 8'd0;
          state_d = sched_we ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        if (xfer_done) begin
          state_d = IDLE;
          if (state_q == READ) begin
            rf_wr_d   = 1'b1;
            rf_tag_d  = tag_q;
            rf_data_d = mem_data_in;
          end
        end else if (xfer_timeout) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      wd_q      <= '0;
      guard_q   <= 1'b0;
      rf_wr_q   <= 1'b0;
      rf_tag_q  <= '0;
      rf_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tag_q     <= tag_d;
      wd_q      <= wd_d;
      guard_q   <= guard_d;
      rf_wr_q   <= rf_wr_d;
      rf_tag_q  <= rf_tag_d;
      rf_data_q <= rf_data_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_core.sv
// Scenario bench for lsu_core: expected bus transfers and register-file writes are
// queued when a request is driven and popped when the unit produces them.
module tb_lsu_core;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        sched_req, sched_we, sched_ack;
  logic [15:0] sched_addr, sched_data;
  logic [3:0]  sched_tag;
  logic        rmw_data_rdy, rmw_deny_op, rmw_ack;
  logic [15:0] rmw_addr, rmw_data;
  logic        mem_req, mem_we, mem_rdy;
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic        rf_wr, bus_err, busy;
  logic [3:0]  rf_wr_tag;
  logic [15:0] rf_wr_data;

  typedef struct packed {logic we; logic [15:0] addr; logic [15:0] data;} bus_t;
  typedef struct packed {logic [3:0] tag; logic [15:0] data;} rf_t;

  bus_t bus_q[$];
  rf_t  rf_q[$];
  bus_t e_bus, o_bus;
  rf_t  e_rf, o_rf;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_core #(.TAG_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .a_rst(a_rst),
    .sched_req(sched_req), .sched_we(sched_we), .sched_addr(sched_addr),
    .sched_data(sched_data), .sched_tag(sched_tag), .sched_ack(sched_ack),
    .rmw_data_rdy(rmw_data_rdy), .rmw_addr(rmw_addr), .rmw_data(rmw_data),
    .rmw_deny_op(rmw_deny_op), .rmw_ack(rmw_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_rdy(mem_rdy), .mem_data_in(mem_data_in),
    .rf_wr(rf_wr), .rf_wr_tag(rf_wr_tag), .rf_wr_data(rf_wr_data),
    .bus_err(bus_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    sched_req = 0; sched_we = 0; sched_addr = 0; sched_data = 0; sched_tag = 0;
    rmw_data_rdy = 0; rmw_addr = 0; rmw_data = 0; rmw_deny_op = 0;
    mem_rdy = 0; mem_data_in = 0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, busy, rf_wr, bus_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {mem_req, mem_we, busy, rf_wr, bus_err});
    end
    n_tests++;
    if ({mem_addr, mem_data_out, rf_wr_data, rf_wr_tag} !== 52'd0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h required zeros", mem_addr, mem_data_out, rf_wr_data, rf_wr_tag);
    end
    a_rst = 1'b0;
  endtask

  task automatic test_load();
    @(negedge clk);
    sched_req = 1; sched_we = 0; sched_addr = 16'h1234; sched_tag = 4'd5; sched_data = 16'hFFFF;
    #1;
    n_tests++;
    if ({sched_ack, rmw_ack} !== 2'b10) begin
      n_fail++; $display("FAIL load_ack: got %b required 10", {sched_ack, rmw_ack});
    end
    bus_q.push_back('{we: 1'b0, addr: 16'h1234, data: 16'h0000});
    rf_q.push_back('{tag: 4'd5, data: 16'hBEEF});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sched_req = 0;
      n_tests++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h1234}) begin
        n_fail++; $display("FAIL load_bus_cyc%0d: req=%b we=%b addr=%h required 1 0 1234", i, mem_req, mem_we, mem_addr);
      end
      if (i == 2) begin
        o_bus = {mem_we, mem_addr, mem_data_out};
        e_bus = bus_q.pop_front();
        n_tests++;
        if (o_bus !== e_bus) begin
          n_fail++; $display("FAIL load_xfer: got %h required %h", o_bus, e_bus);
        end
        mem_rdy = 1; mem_data_in = 16'hBEEF;
      end
    end
    @(negedge clk);
    mem_rdy = 0; mem_data_in = 16'h0000;
    n_tests++;
    if ({mem_req, rf_wr} !== 2'b01) begin
      n_fail++; $display("FAIL load_rf_wr: req/rf_wr=%b required 01", {mem_req, rf_wr});
    end else begin
      o_rf = {rf_wr_tag, rf_wr_data};
      e_rf = rf_q.pop_front();
      n_tests++;
      if (o_rf !== e_rf) begin
        n_fail++; $display("FAIL load_rf_data: got %h required %h", o_rf, e_rf);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({rf_wr, rf_wr_tag, rf_wr_data} !== {1'b0, 4'd5, 16'hBEEF}) begin
      n_fail++; $display("FAIL load_rf_hold: got %b %h %h required 0 5 beef", rf_wr, rf_wr_tag, rf_wr_data);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    sched_req = 1; sched_we = 1; sched_addr = 16'h0010; sched_data = 16'h00AA; sched_tag = 4'd9;
    #1;
    n_tests++;
    if (sched_ack !== 1'b1) begin
      n_fail++; $display("FAIL store_ack: got %b required 1", sched_ack);
    end
    bus_q.push_back('{we: 1'b1, addr: 16'h0010, data: 16'h00AA});
    @(negedge clk);
    sched_req = 0;
    o_bus = {mem_we, mem_addr, mem_data_out};
    e_bus = bus_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b1 || o_bus !== e_bus) begin
      n_fail++; $display("FAIL store_xfer: req=%b got %h required %h", mem_req, o_bus, e_bus);
    end
    mem_rdy = 1;
    @(negedge clk);
    mem_rdy = 0;
    n_tests++;
    if ({busy, mem_req, mem_we, rf_wr} !== 4'b0) begin
      n_fail++; $display("FAIL store_done: busy/req/we/rf_wr=%b required 0000", {busy, mem_req, mem_we, rf_wr});
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    sched_req = 1; sched_we = 0; sched_addr = 16'h2000; sched_tag = 4'd3;
    rmw_data_rdy = 1; rmw_addr = 16'h3000; rmw_data = 16'h0001;
    #1;
    n_tests++;
    if ({rmw_ack, sched_ack} !== 2'b10) begin
      n_fail++; $display("FAIL prio_ack: rmw/sched=%b required 10", {rmw_ack, sched_ack});
    end
    bus_q.push_back('{we: 1'b1, addr: 16'h3000, data: 16'h0001});
    @(negedge clk);
    o_bus = {mem_we, mem_addr, mem_data_out};
    e_bus = bus_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b1 || o_bus !== e_bus) begin
      n_fail++; $display("FAIL prio_rmw_xfer: req=%b got %h required %h", mem_req, o_bus, e_bus);
    end
    mem_rdy = 1;
    #1;
    n_tests++;
    if ({rmw_ack, sched_ack} !== 2'b00) begin
      n_fail++; $display("FAIL busy_acks: rmw/sched=%b required 00", {rmw_ack, sched_ack});
    end
    @(negedge clk);
    mem_rdy = 0;
    #1;
    n_tests++;
    if ({busy, rmw_ack, sched_ack} !== 3'b001) begin
      n_fail++; $display("FAIL prio_guard: busy/rmw/sched=%b required 001", {busy, rmw_ack, sched_ack});
    end
    bus_q.push_back('{we: 1'b0, addr: 16'h2000, data: 16'h0000});
    rf_q.push_back('{tag: 4'd3, data: 16'h5A5A});
    @(negedge clk);
    sched_req = 0; rmw_data_rdy = 0;
    o_bus = {mem_we, mem_addr, mem_data_out};
    e_bus = bus_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b1 || o_bus !== e_bus) begin
      n_fail++; $display("FAIL prio_load_xfer: req=%b got %h required %h", mem_req, o_bus, e_bus);
    end
    mem_rdy = 1; mem_data_in = 16'h5A5A;
    @(negedge clk);
    mem_rdy = 0; mem_data_in = 0;
    o_rf = {rf_wr_tag, rf_wr_data};
    e_rf = rf_q.pop_front();
    n_tests++;
    if (rf_wr !== 1'b1 || o_rf !== e_rf) begin
      n_fail++; $display("FAIL prio_load_rf: rf_wr=%b got %h required %h", rf_wr, o_rf, e_rf);
    end
  endtask

  task automatic test_deny();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rmw_deny_op = 1; sched_req = 1; sched_we = 1; sched_addr = 16'h4000; sched_data = 16'h1111;
      #1;
      n_tests++;
      if ({sched_ack, busy} !== 2'b00) begin
        n_fail++; $display("FAIL deny_cyc%0d: sched_ack/busy=%b required 00", i, {sched_ack, busy});
      end
    end
    @(negedge clk);
    rmw_deny_op = 0;
    #1;
    n_tests++;
    if (sched_ack !== 1'b1) begin
      n_fail++; $display("FAIL deny_release: sched_ack=%b required 1", sched_ack);
    end
    bus_q.push_back('{we: 1'b1, addr: 16'h4000, data: 16'h1111});
    @(negedge clk);
    sched_req = 0;
    o_bus = {mem_we, mem_addr, mem_data_out};
    e_bus = bus_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b1 || o_bus !== e_bus) begin
      n_fail++; $display("FAIL deny_xfer: req=%b got %h required %h", mem_req, o_bus, e_bus);
    end
    mem_rdy = 1;
    @(negedge clk);
    mem_rdy = 0;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    sched_req = 1; sched_we = 0; sched_addr = 16'h5555; sched_tag = 4'd7;
    @(negedge clk);
    sched_req = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if ({mem_req, bus_err} !== 2'b10) begin
        n_fail++; $display("FAIL tmo_cyc%0d: req/bus_err=%b required 10", i, {mem_req, bus_err});
      end
    end
    @(negedge clk);
    n_tests++;
    if ({mem_req, bus_err, rf_wr, busy} !== 4'b0100) begin
      n_fail++; $display("FAIL tmo_abort: req/bus_err/rf_wr/busy=%b required 0100", {mem_req, bus_err, rf_wr, busy});
    end
    @(negedge clk);
    n_tests++;
    if ({bus_err, rf_wr} !== 2'b00) begin
      n_fail++; $display("FAIL tmo_pulse: bus_err/rf_wr=%b required 00", {bus_err, rf_wr});
    end
    sched_req = 1; sched_we = 0; sched_addr = 16'h6666; sched_tag = 4'd8;
    bus_q.push_back('{we: 1'b0, addr: 16'h6666, data: 16'h0000});
    rf_q.push_back('{tag: 4'd8, data: 16'hCAFE});
    @(negedge clk);
    sched_req = 0;
    repeat (3) @(negedge clk);
    o_bus = {mem_we, mem_addr, mem_data_out};
    e_bus = bus_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b1 || o_bus !== e_bus) begin
      n_fail++; $display("FAIL tmo_edge_xfer: req=%b got %h required %h", mem_req, o_bus, e_bus);
    end
    mem_rdy = 1; mem_data_in = 16'hCAFE;
    @(negedge clk);
    mem_rdy = 0; mem_data_in = 0;
    o_rf = {rf_wr_tag, rf_wr_data};
    e_rf = rf_q.pop_front();
    n_tests++;
    if ({rf_wr, bus_err, busy} !== 3'b100 || o_rf !== e_rf) begin
      n_fail++; $display("FAIL tmo_edge_done: rf_wr/bus_err/busy=%b got %h required 100 %h", {rf_wr, bus_err, busy}, o_rf, e_rf);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    sched_req = 1; sched_we = 1; sched_addr = 16'h7777; sched_data = 16'h1234;
    @(negedge clk);
    sched_req = 0;
    n_tests++;
    if ({mem_req, mem_we} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_pre: req/we=%b required 11", {mem_req, mem_we});
    end
    @(negedge clk);
    a_rst = 1;
    #1;
    n_tests++;
    if ({mem_req, mem_we, busy, rf_wr, bus_err, mem_addr, mem_data_out, rf_wr_tag, rf_wr_data} !== 57'd0) begin
      n_fail++; $display("FAIL rst_mid_async: req=%b we=%b busy=%b addr=%h dout=%h tag=%h rdata=%h required zeros",
                         mem_req, mem_we, busy, mem_addr, mem_data_out, rf_wr_tag, rf_wr_data);
    end
    @(negedge clk);
    a_rst = 0;
    @(negedge clk);
    n_tests++;
    if ({busy, bus_err, rf_wr} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_after: busy/bus_err/rf_wr=%b required 000", {busy, bus_err, rf_wr});
    end
    sched_req = 1; sched_we = 0; sched_addr = 16'h0042; sched_tag = 4'd2;
    bus_q.push_back('{we: 1'b0, addr: 16'h0042, data: 16'h0000});
    rf_q.push_back('{tag: 4'd2, data: 16'h1357});
    @(negedge clk);
    sched_req = 0;
    @(negedge clk);
    o_bus = {mem_we, mem_addr, mem_data_out};
    e_bus = bus_q.pop_front();
    n_tests++;
    if (mem_req !== 1'b1 || o_bus !== e_bus) begin
      n_fail++; $display("FAIL rst_mid_load_xfer: req=%b got %h required %h", mem_req, o_bus, e_bus);
    end
    mem_rdy = 1; mem_data_in = 16'h1357;
    @(negedge clk);
    mem_rdy = 0; mem_data_in = 0;
    o_rf = {rf_wr_tag, rf_wr_data};
    e_rf = rf_q.pop_front();
    n_tests++;
    if ({rf_wr, bus_err} !== 2'b10 || o_rf !== e_rf) begin
      n_fail++; $display("FAIL rst_mid_load_rf: rf_wr/bus_err=%b got %h required 10 %h", {rf_wr, bus_err}, o_rf, e_rf);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_priority();
    test_deny();
    test_timeout();
    test_reset_mid_op();
    n_tests++;
    if (bus_q.size() != 0 || rf_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: bus=%0d rf=%0d left, required 0 0", bus_q.size(), rf_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
